sobel_dut_system: RTL and testbench

Streaming 3x3 Sobel edge-detection pipeline: RGB input FIFO → three parallel grayscale converters → grayscale FIFO → Sobel column-window engine → output FIFO. The testbench writes one column of three vertically stacked RGB pixels per word and reads one 8-bit edge magnitude per word. It is the top-level datapath of the Sobel system and has no frame awareness; the stream is unbounded.

---
 rtl/sobel_dut_system.sv | 256 +++++++++++++++++++++++++
 tb/tb_sobel_dut_system.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_dut_system.sv
// sobel_dut_system
//
// Streaming 3x3 Sobel edge-detection datapath:
//   RGB FIFO -> NUM_GRAYSCALES grayscale converters -> gray FIFO
//   -> Sobel column-window engine(s) -> output FIFO.
// Each input word is one column of three vertically stacked RGB pixels
// (pixel 0 = top row). Each output word is one 8-bit edge magnitude.
// No frame awareness: the column stream is unbounded, and a result is
// produced for every column once two earlier columns have been seen.
//
// Ports:
//   clock            single clock, rising edge
//   reset            asynchronous, active-high; clears all state
//   fifo_rgb_din     pixel p at [24p+23:24p], within a pixel B/G/R = [23:16]/[15:8]/[7:0]
//   fifo_rgb_wr_en   write strobe, dropped while fifo_rgb_full
//   fifo_rgb_full    input FIFO full
//   fifo_sobel_dout  head of the output FIFO (first-word-fall-through)
//   fifo_sobel_empty output FIFO empty
//   fifo_sobel_rd_en pops the output head, ignored while empty

// Synchronous first-word-fall-through FIFO with occupancy counter.
// The head is read straight out of the storage array so that dout is
// valid in the same cycle that empty drops.
module sobel_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] din,
    output logic              full,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] dout,
    output logic              empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              wr_ok;
    logic              rd_ok;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign wr_ok = wr_en && !full;   // a write while full is lost even if a read frees a slot
    assign rd_ok = rd_en && !empty;
    assign dout  = mem_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (wr_ok && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

module sobel_dut_system #(
    parameter int NUM_SOBELS       = 1,
    parameter int NUM_GRAYSCALES   = 3,
    parameter int RGB_DWIDTH       = 72,
    parameter int RGB_BUFFER       = 2,
    parameter int GRAYSCALE_DWIDTH = 24,
    parameter int GRAYSCALE_BUFFER = 2,
    parameter int SOBEL_DWIDTH     = 8,
    parameter int SOBEL_BUFFER     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [RGB_DWIDTH-1:0]   fifo_rgb_din,
    input  logic                    fifo_rgb_wr_en,
    output logic                    fifo_rgb_full,
    output logic [SOBEL_DWIDTH-1:0] fifo_sobel_dout,
    output logic                    fifo_sobel_empty,
    input  logic                    fifo_sobel_rd_en
);
    typedef enum logic [1:0] {
        COL_EMPTY,  // no previous column held
        COL_ONE,    // one previous column held
        COL_FULL    // two previous columns held; every new column yields a result
    } col_state_t;

    logic [RGB_DWIDTH-1:0]       rgb_dout;
    logic                        rgb_empty;
    logic [GRAYSCALE_DWIDTH-1:0] gray_din;
    logic [GRAYSCALE_DWIDTH-1:0] gray_dout;
    logic                        gray_full;
    logic                        gray_empty;
    logic [SOBEL_DWIDTH-1:0]     sobel_din;
    logic                        sobel_full;
    logic                        gray_fire;
    logic                        sobel_fire;
    logic                        sobel_push;
    col_state_t                  state_reg;
    col_state_t                  state_next;

    // Weighted column/row sum a + 2b + c; at most 1020, so 11 bits hold
    // it and the difference of two such sums without overflow.
    function automatic logic [10:0] weight3(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    sobel_fifo #(.DWIDTH(RGB_DWIDTH), .DEPTH(RGB_BUFFER)) u_fifo_rgb (
        .clock (clock),
        .reset (reset),
        .wr_en (fifo_rgb_wr_en),
        .din   (fifo_rgb_din),
        .full  (fifo_rgb_full),
        .rd_en (gray_fire),
        .dout  (rgb_dout),
        .empty (rgb_empty)
    );

    // Grayscale stage: one RGB column in, one gray column out, same cycle.
    assign gray_fire = !rgb_empty && !gray_full;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GRAYSCALES; gi++) begin : g_gray
            logic [9:0] sum;
            logic [9:0] quot;
            assign sum  = {2'b00, rgb_dout[24*gi +: 8]}
                        + {2'b00, rgb_dout[24*gi + 8 +: 8]}
                        + {2'b00, rgb_dout[24*gi + 16 +: 8]};
            assign quot = sum / 10'd3;   // <= 255, upper bits always zero
            assign gray_din[8*gi +: 8] = quot[7:0];
        end
    endgenerate

    sobel_fifo #(.DWIDTH(GRAYSCALE_DWIDTH), .DEPTH(GRAYSCALE_BUFFER)) u_fifo_gray (
        .clock (clock),
        .reset (reset),
        .wr_en (gray_fire),
        .din   (gray_din),
        .full  (gray_full),
        .rd_en (sobel_fire),
        .dout  (gray_dout),
        .empty (gray_empty)
    );

    // Window fill tracking. Until two columns are held the engine only
    // shifts, so it does not depend on room in the output FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= COL_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sobel_fire = 1'b0;
        sobel_push = 1'b0;
        case (state_reg)
            COL_EMPTY: begin
                if (!gray_empty) begin
                    sobel_fire = 1'b1;
                    state_next = COL_ONE;
                end
            end
            COL_ONE: begin
                if (!gray_empty) begin
                    sobel_fire = 1'b1;
                    state_next = COL_FULL;
                end
            end
            COL_FULL: begin
                if (!gray_empty && !sobel_full) begin
                    sobel_fire = 1'b1;
                    sobel_push = 1'b1;
                end
            end
            default: state_next = COL_EMPTY;
        endcase
    end

    // Sobel engines; each owns a 24-bit gray column slice and one output byte.
    generate
        for (gi = 0; gi < NUM_SOBELS; gi++) begin : g_sobel
            logic [23:0] c0_reg;
            logic [23:0] c1_reg;
            logic [23:0] c2;
            logic [10:0] gx_diff;
            logic [10:0] gy_diff;
            logic [10:0] gx_abs;
            logic [10:0] gy_abs;
            logic [10:0] half_mag;

            assign c2 = gray_dout[24*gi +: 24];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    c0_reg <= '0;
                    c1_reg <= '0;
                end else if (sobel_fire) begin
                    c0_reg <= c1_reg;
                    c1_reg <= c2;
                end
            end

            // Differences wrap modulo 2^11; bit 10 is the sign of the
            // true value since |G| <= 1020.
            assign gx_diff = weight3(c2[7:0], c2[15:8], c2[23:16])
                           - weight3(c0_reg[7:0], c0_reg[15:8], c0_reg[23:16]);
            assign gy_diff = weight3(c0_reg[7:0], c1_reg[7:0], c2[7:0])
                           - weight3(c0_reg[23:16], c1_reg[23:16], c2[23:16]);
            assign gx_abs  = gx_diff[10] ? (~gx_diff + 11'd1) : gx_diff;
            assign gy_abs  = gy_diff[10] ? (~gy_diff + 11'd1) : gy_diff;
            assign half_mag = 11'(({1'b0, gx_abs} + {1'b0, gy_abs}) >> 1);
            assign sobel_din[8*gi +: 8] = (half_mag > 11'd255) ? 8'd255 : half_mag[7:0];
        end
    endgenerate

    sobel_fifo #(.DWIDTH(SOBEL_DWIDTH), .DEPTH(SOBEL_BUFFER)) u_fifo_sobel (
        .clock (clock),
        .reset (reset),
        .wr_en (sobel_push),
        .din   (sobel_din),
        .full  (sobel_full),
        .rd_en (fifo_sobel_rd_en),
        .dout  (fifo_sobel_dout),
        .empty (fifo_sobel_empty)
    );
endmodule

// File: tb/tb_sobel_dut_system.sv
// Self-checking bench for sobel_dut_system: directed scenarios plus a
// random column stream, checked against a column-queue reference model.
module tb_sobel_dut_system;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [71:0] fifo_rgb_din = '0;
    logic        fifo_rgb_wr_en = 1'b0;
    logic        fifo_rgb_full;
    logic [7:0]  fifo_sobel_dout;
    logic        fifo_sobel_empty;
    logic        fifo_sobel_rd_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    // Reference model: gray rows of every column accepted since reset,
    // and the queue of results still owed by the DUT.
    int gt[$];
    int gm[$];
    int gb[$];
    int exp_q[$];

    sobel_dut_system dut (
        .clock            (clock),
        .reset            (reset),
        .fifo_rgb_din     (fifo_rgb_din),
        .fifo_rgb_wr_en   (fifo_rgb_wr_en),
        .fifo_rgb_full    (fifo_rgb_full),
        .fifo_sobel_dout  (fifo_sobel_dout),
        .fifo_sobel_empty (fifo_sobel_empty),
        .fifo_sobel_rd_en (fifo_sobel_rd_en)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] pix(input int r, input int g, input int b);
        return {8'(b), 8'(g), 8'(r)};
    endfunction

    function automatic logic [71:0] col3(input logic [23:0] p0, input logic [23:0] p1,
                                         input logic [23:0] p2);
        return {p2, p1, p0};
    endfunction

    function automatic logic [71:0] rand_word();
        logic [71:0] w;
        w[31:0]  = $urandom;
        w[63:32] = $urandom;
        w[71:64] = 8'($urandom);
        return w;
    endfunction

    function automatic int gray_of(input logic [23:0] p);
        return (int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16])) / 3;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        gt.delete();
        gm.delete();
        gb.delete();
        exp_q.delete();
    endtask

    // Column accepted by the DUT: record its grays and, once three
    // columns exist, the Sobel result of the newest 3x3 window.
    task automatic model_accept(input logic [71:0] w);
        int n, a, b, c, gx, gy, mag;
        gt.push_back(gray_of(w[23:0]));
        gm.push_back(gray_of(w[47:24]));
        gb.push_back(gray_of(w[71:48]));
        n = gt.size();
        if (n >= 3) begin
            a = n - 3;
            b = n - 2;
            c = n - 1;
            gx = (gt[c] + 2 * gm[c] + gb[c]) - (gt[a] + 2 * gm[a] + gb[a]);
            gy = (gt[a] + 2 * gt[b] + gt[c]) - (gb[a] + 2 * gb[b] + gb[c]);
            mag = (iabs(gx) + iabs(gy)) / 2;
            exp_q.push_back((mag > 255) ? 255 : mag);
        end
    endtask

    // One clock cycle. Called at posedge+1; any output present now and
    // read with rd is checked against the model before it is popped.
    task automatic tick(input logic wr, input logic [71:0] din, input logic rd);
        fifo_rgb_wr_en   = wr;
        fifo_rgb_din     = din;
        fifo_sobel_rd_en = rd;
        if (rd && !fifo_sobel_empty) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL extra_output: observed dout %0d, expected no output", fifo_sobel_dout);
            end
            if (exp_q.size() > 0) begin
                $display("read %0d: dout=%0d expected=%0d", n_out, fifo_sobel_dout, exp_q[0]);
                check("dout", 32'(fifo_sobel_dout), 32'(exp_q.pop_front()));
            end
            n_out++;
        end
        @(posedge clock);
        #1;
        fifo_rgb_wr_en   = 1'b0;
        fifo_sobel_rd_en = 1'b0;
    endtask

    task automatic write_acc(input logic [71:0] w, input logic rd);
        tick(1'b1, w, rd);
        model_accept(w);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        check({tag, "_empty"}, 32'(fifo_sobel_empty), 32'd1);
        check({tag, "_full"},  32'(fifo_rgb_full),    32'd0);
        check({tag, "_dout"},  32'(fifo_sobel_dout),  32'd0);
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (exp_q.size() > 0 || !fifo_sobel_empty); i++) begin
            tick(1'b0, '0, 1'b1);
        end
        check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_empty"},   32'(fifo_sobel_empty), 32'd1);
    endtask

    initial begin
        logic [71:0] w;
        logic [71:0] z;
        int n_acc;

        z = col3(pix(0, 0, 0), pix(0, 0, 0), pix(0, 0, 0));

        // Power-up reset
        #2;
        do_reset("init");

        // Uniform gray 90: three results of 0, first two cycles after 3rd write
        w = col3(pix(90, 90, 90), pix(90, 90, 90), pix(90, 90, 90));
        n_out = 0;
        write_acc(w, 1'b0);
        write_acc(w, 1'b0);
        write_acc(w, 1'b0);
        check("uni_empty_k", 32'(fifo_sobel_empty), 32'd1);
        tick(1'b0, '0, 1'b0);
        check("uni_empty_k1", 32'(fifo_sobel_empty), 32'd1);
        tick(1'b0, '0, 1'b0);
        check("uni_empty_k2", 32'(fifo_sobel_empty), 32'd0);
        check("uni_first", 32'(fifo_sobel_dout), 32'd0);
        write_acc(w, 1'b1);
        write_acc(w, 1'b1);
        drain("uni");
        check("uni_count", 32'(n_out), 32'd3);

        // Vertical edge: gray 0, 0, 60 -> 120
        do_reset("rst_v");
        n_out = 0;
        write_acc(z, 1'b0);
        write_acc(z, 1'b0);
        write_acc(col3(pix(60, 60, 60), pix(60, 60, 60), pix(60, 60, 60)), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("vert_val", 32'(fifo_sobel_dout), 32'd120);
        drain("vert");
        check("vert_count", 32'(n_out), 32'd1);

        // Horizontal edge with truncating gray (101+100+100)/3 = 100 -> 200
        do_reset("rst_h");
        n_out = 0;
        w = col3(pix(0, 0, 0), pix(0, 0, 0), pix(101, 100, 100));
        write_acc(w, 1'b0);
        write_acc(w, 1'b0);
        write_acc(w, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("horiz_val", 32'(fifo_sobel_dout), 32'd200);
        drain("horiz");
        check("horiz_count", 32'(n_out), 32'd1);

        // Saturation: 0, 0, 255 -> min(255, 510)
        do_reset("rst_s");
        write_acc(z, 1'b0);
        write_acc(z, 1'b0);
        write_acc(col3(pix(255, 255, 255), pix(255, 255, 255), pix(255, 255, 255)), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("sat_val", 32'(fifo_sobel_dout), 32'd255);
        drain("sat");

        // Backpressure: stalled consumer. Capacity = 2 results in the
        // output FIFO (needing 4 columns) + 2 gray + 2 RGB = 8 columns.
        do_reset("rst_bp");
        n_out = 0;
        for (int i = 0; i < 10; i++) begin
            w = rand_word();
            tick(1'b1, w, 1'b0);
            if (i < 8) model_accept(w);
        end
        check("bp_full", 32'(fifo_rgb_full), 32'd1);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("bp_full_hold", 32'(fifo_rgb_full), 32'd1);
        check("bp_not_empty", 32'(fifo_sobel_empty), 32'd0);
        drain("bp");
        check("bp_count", 32'(n_out), 32'd6);
        check("bp_full_clear", 32'(fifo_rgb_full), 32'd0);

        // Reset mid-stream: only post-reset columns may contribute
        do_reset("rst_m0");
        for (int i = 0; i < 4; i++) write_acc(rand_word(), 1'b1);
        do_reset("rst_mid");
        n_out = 0;
        write_acc(rand_word(), 1'b1);
        write_acc(rand_word(), 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1);
        check("mid_no_output", 32'(fifo_sobel_empty), 32'd1);
        write_acc(rand_word(), 1'b1);
        drain("mid");
        check("mid_count", 32'(n_out), 32'd1);

        // Random stream with a consumer reading every cycle
        do_reset("rst_r");
        n_out = 0;
        n_acc = 0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                write_acc(rand_word(), 1'b1);
                n_acc++;
            end else begin
                tick(1'b0, '0, 1'b1);
            end
        end
        drain("rand");
        check("rand_count", 32'(n_out), 32'((n_acc > 2) ? n_acc - 2 : 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
